branch_predict_bht: RTL and testbench

Branch history table that supplies `predict_taken` to the branch control-hazard FSM in the fetch/decode stage and learns from resolved outcomes. It holds ENTRIES 2-bit saturating counters indexed by low PC bits and tracks the single in-flight predicted branch. It flags mispredictions in the resolve cycle and keeps saturating branch and mispredict statistics.

---
 rtl/branch_predict_bht.sv | 132 +++++++++++++
 tb/tb_branch_predict_bht.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_bht.sv
// branch_predict_bht
//   Branch history table of 2-bit saturating counters indexed by low PC bits.
//   Supplies a same-cycle prediction for the branch at fetch/decode, tracks the
//   single in-flight predicted branch for one cycle, learns from its resolved
//   outcome, flags mispredictions and keeps saturating statistics.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   reset_n          : asynchronous active-low reset
//   lookup_valid     : branch present at fetch/decode this cycle
//   lookup_pc        : PC of that branch
//   predict_taken    : combinational prediction (0 when lookup_valid=0)
//   resolve_valid    : outcome of the pending branch available this cycle
//   resolve_taken    : actual branch direction
//   flush            : squash, do not capture a new lookup this cycle
//   mispredict       : combinational misprediction flag in the resolve cycle
//   branch_count     : resolved branches, saturating
//   mispredict_count : mispredictions, saturating
//   stats_clear      : synchronous clear of both counts and protocol_err
//   protocol_err     : sticky, resolve seen while no branch was pending
module branch_predict_bht #(
  parameter int ENTRIES = 16,
  parameter int IDX_LSB = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic        flush,
  output logic        mispredict,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count,
  input  logic        stats_clear,
  output logic        protocol_err
);

  localparam int IW = $clog2(ENTRIES);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t         state, state_next;
  logic [1:0]     tbl [ENTRIES];
  logic [IW-1:0]  pending_idx;
  logic           pending_pred;
  logic           pending_valid;
  logic [IW-1:0]  lookup_idx;
  logic           do_update;
  logic           capture;
  logic [1:0]     upd_val;
  logic [1:0]     look_val;
  logic           unused_pc;

  // Upper PC bits (and those below IDX_LSB) deliberately alias.
  assign unused_pc     = ^lookup_pc;
  assign lookup_idx    = lookup_pc[IDX_LSB +: IW];
  assign pending_valid = (state == PEND);
  assign do_update     = resolve_valid & pending_valid;
  assign capture       = lookup_valid & ~flush;
  assign upd_val       = resolve_taken ? sat_inc2(tbl[pending_idx])
                                       : sat_dec2(tbl[pending_idx]);

  // Bypass: a lookup hitting the entry being written sees the new value, so
  // back-to-back executions of the same branch predict from fresh state.
  assign look_val      = (do_update && (pending_idx == lookup_idx)) ? upd_val
                                                                     : tbl[lookup_idx];
  assign predict_taken = lookup_valid & look_val[1];
  assign mispredict    = do_update & (pending_pred != resolve_taken);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A pending branch lives exactly one cycle; a resolve is consumed in PEND
  // whatever the next state is.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = capture ? PEND : IDLE;
      PEND:    state_next = capture ? PEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pending payload is only meaningful while state==PEND, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      pending_idx  <= lookup_idx;
      pending_pred <= predict_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
    end else if (do_update) begin
      tbl[pending_idx] <= upd_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      protocol_err     <= 1'b0;
    end else if (stats_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      protocol_err     <= 1'b0;
    end else begin
      if (do_update)                       branch_count     <= sat_inc16(branch_count);
      if (mispredict)                      mispredict_count <= sat_inc16(mispredict_count);
      if (resolve_valid && !pending_valid) protocol_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_bht.sv
// tb_branch_predict_bht
//   Directed stimulus for branch_predict_bht with a per-cycle comparison
//   against a behavioural table model, plus hand-computed literal checks.
module tb_branch_predict_bht;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        flush;
  logic        mispredict;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic        stats_clear;
  logic        protocol_err;

  int total  = 0;
  int passed = 0;

  branch_predict_bht #(.ENTRIES(16), .IDX_LSB(1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .stats_clear      (stats_clear),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: counters as plain integers 0..3, counts as integers.
  int m_tbl [16];
  bit m_pv;
  int m_pidx;
  bit m_ppred;
  int m_bc, m_mc;
  bit m_perr;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 1) % 16);
  endfunction

  function automatic int next_ctr(input int v, input bit taken);
    if (taken) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic bit exp_pred();
    int v;
    v = m_tbl[idx_of(lookup_pc)];
    if (resolve_valid && m_pv && m_pidx == idx_of(lookup_pc))
      v = next_ctr(v, resolve_taken);
    return lookup_valid && (v >= 2);
  endfunction

  function automatic bit exp_misp();
    return resolve_valid && m_pv && (m_ppred != resolve_taken);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit lp, mp;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_tbl[i] = 1;
      m_pv = 0; m_pidx = 0; m_ppred = 0;
      m_bc = 0; m_mc = 0; m_perr = 0;
    end else begin
      lp = exp_pred();
      mp = exp_misp();
      if (stats_clear) begin
        m_bc = 0; m_mc = 0; m_perr = 0;
      end else begin
        if (resolve_valid && m_pv) m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
        if (mp)                    m_mc = (m_mc < 65535) ? m_mc + 1 : 65535;
        if (resolve_valid && !m_pv) m_perr = 1;
      end
      if (resolve_valid && m_pv) m_tbl[m_pidx] = next_ctr(m_tbl[m_pidx], resolve_taken);
      if (lookup_valid && !flush) begin
        m_pv = 1; m_pidx = idx_of(lookup_pc); m_ppred = lp;
      end else begin
        m_pv = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_predict_taken", {31'd0, predict_taken}, {31'd0, exp_pred()});
    check("model_mispredict",    {31'd0, mispredict},    {31'd0, exp_misp()});
    check("model_branch_count",  {16'd0, branch_count},  m_bc);
    check("model_mispred_count", {16'd0, mispredict_count}, m_mc);
    check("model_protocol_err",  {31'd0, protocol_err},  {31'd0, m_perr});
  end

  task automatic step(input bit lv, input logic [31:0] pc, input bit rv, input bit rt,
                      input bit fl, input bit sc);
    @(posedge clk); #1;
    lookup_valid = lv; lookup_pc = pc; resolve_valid = rv;
    resolve_taken = rt; flush = fl; stats_clear = sc;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    resolve_valid = 0; resolve_taken = 0; flush = 0; stats_clear = 0;
    repeat (2) @(negedge clk);
    check("reset_predict", {31'd0, predict_taken}, 0);
    check("reset_mispredict", {31'd0, mispredict}, 0);
    check("reset_bcount", {16'd0, branch_count}, 0);
    check("reset_perr", {31'd0, protocol_err}, 0);
    reset_n = 1'b1;

    // Learn 0x100 taken twice.
    step(1, 32'h100, 0, 0, 0, 0); check("it1_predict", {31'd0, predict_taken}, 0);
    step(0, 32'h0,   1, 1, 0, 0); check("it1_mispredict", {31'd0, mispredict}, 1);
    step(1, 32'h100, 0, 0, 0, 0); check("it2_predict", {31'd0, predict_taken}, 1);
    step(0, 32'h0,   1, 1, 0, 0); check("it2_mispredict", {31'd0, mispredict}, 0);
    step(1, 32'h100, 0, 0, 0, 0); check("it3_predict", {31'd0, predict_taken}, 1);
    idle();
    check("learn_bcount", {16'd0, branch_count}, 2);
    check("learn_mcount", {16'd0, mispredict_count}, 1);

    // Mid-operation reset discards everything immediately.
    @(posedge clk); #1; reset_n = 1'b0; #1;
    check("midreset_bcount", {16'd0, branch_count}, 0);
    check("midreset_mcount", {16'd0, mispredict_count}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Same-index bypass: 0x120 aliases index 0.
    step(1, 32'h100, 0, 0, 0, 0); check("byp_first_predict", {31'd0, predict_taken}, 0);
    step(1, 32'h120, 1, 1, 0, 0);
    check("bypass_predict", {31'd0, predict_taken}, 1);
    check("bypass_mispredict", {31'd0, mispredict}, 1);
    idle();

    // Resolve with nothing pending.
    step(0, 32'h0, 1, 1, 0, 0); check("orphan_mispredict", {31'd0, mispredict}, 0);
    idle();
    check("orphan_perr", {31'd0, protocol_err}, 1);
    check("orphan_bcount", {16'd0, branch_count}, 1);
    step(0, 32'h0, 0, 0, 0, 1);
    idle();
    check("clear_perr", {31'd0, protocol_err}, 0);
    check("clear_bcount", {16'd0, branch_count}, 0);

    // Flushed lookup is not captured; table[2] stays weakly-not-taken.
    step(1, 32'h104, 0, 0, 1, 0); check("flush_predict", {31'd0, predict_taken}, 0);
    step(0, 32'h0,   1, 1, 0, 0); check("flush_mispredict", {31'd0, mispredict}, 0);
    idle();
    check("flush_perr", {31'd0, protocol_err}, 1);
    check("flush_bcount", {16'd0, branch_count}, 0);
    step(1, 32'h104, 0, 0, 0, 0); check("t2_predict", {31'd0, predict_taken}, 0);
    step(0, 32'h0,   1, 1, 0, 0); check("t2_mispredict", {31'd0, mispredict}, 1);
    step(1, 32'h104, 0, 0, 0, 0); check("t2_learned", {31'd0, predict_taken}, 1);
    // Flush alongside a resolve: older branch updates, new lookup dropped.
    step(1, 32'h104, 1, 0, 1, 0); check("flushres_predict", {31'd0, predict_taken}, 0);
    idle();

    // Saturation with every resolve mispredicted.
    step(1, 32'h100, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk); #1;
      lookup_valid = 1; lookup_pc = 32'h100; resolve_valid = 1;
      resolve_taken = ~m_ppred; flush = 0; stats_clear = 0;
    end
    idle();
    check("sat_bcount", {16'd0, branch_count}, 32'hFFFF);
    check("sat_mcount", {16'd0, mispredict_count}, 32'hFFFF);
    step(1, 32'h100, 0, 0, 0, 0);
    step(0, 32'h0,   1, 1, 0, 1);
    idle();
    check("clrres_bcount", {16'd0, branch_count}, 0);
    check("clrres_mcount", {16'd0, mispredict_count}, 0);

    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
